// File: rtl/pwr_pkg.sv
// Shared types and defaults for the PWR domain stop handshake responder.
package pwr_pkg;

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        ISO   = 3'd1,
        OFF   = 3'd2,
        ON    = 3'd3,
        DEISO = 3'd4,
        WKUP  = 3'd5
    } pwr_dom_st_e;

    localparam int unsigned ISO_CYC_DEF = 4;
    localparam int unsigned PUP_CYC_DEF = 16;
    localparam int unsigned CW_DEF      = 5;

    // Isolation stays on from ISO entry until DEISO entry.
    function automatic logic is_iso_state(input pwr_dom_st_e st);
        return (st == ISO) || (st == OFF) || (st == ON);
    endfunction

endpackage

// File: rtl/pwr_dom_fsm.sv
// One power domain: stop/wake sequencer, shared delay counter and sticky standby flag.
module pwr_dom_fsm
    import pwr_pkg::*;
#(
    parameter int unsigned ISO_CYC = ISO_CYC_DEF,
    parameter int unsigned PUP_CYC = PUP_CYC_DEF,
    parameter int unsigned CW      = CW_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        wake_i,
    input  logic        entry_gate_i,
    input  logic        exit_gate_i,
    input  logic        pwr_ok_i,
    input  logic        sbf_clr_i,
    output pwr_dom_st_e state_o,
    output logic        wkup_o,
    output logic        iso_en_o,
    output logic        pwr_off_o,
    output logic        sbf_o
);

    localparam logic [CW-1:0] ISO_LD = CW'(ISO_CYC - 1);
    localparam logic [CW-1:0] PUP_LD = CW'(PUP_CYC - 1);

    pwr_dom_st_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_dec;
    logic          pend_q, pend_d;
    logic          sbf_q, sbf_d;
    logic          wkup_q, wkup_d;
    logic          iso_q, iso_d;
    logic          off_q, off_d;

    assign cnt_dec = (cnt_q == {CW{1'b0}}) ? {CW{1'b0}} : cnt_q - CW'(1);

    // Next state, counter, pending wake and sticky flag; outputs decoded from next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        case (state_q)
            RUN: begin
                if (req_i && entry_gate_i) begin
                    state_d = ISO;
                    cnt_d   = ISO_LD;
                end else begin
                    cnt_d   = {CW{1'b0}};
                end
            end
            ISO: begin
                if (wake_i || !req_i) begin
                    state_d = DEISO;
                    cnt_d   = ISO_LD;
                end else if (cnt_q == {CW{1'b0}}) begin
                    state_d = OFF;
                end else begin
                    cnt_d   = cnt_dec;
                end
            end
            OFF: begin
                // A wake that arrives while the exit gate is closed is remembered until it opens.
                if (exit_gate_i && (wake_i || pend_q || !req_i)) begin
                    state_d = ON;
                    cnt_d   = PUP_LD;
                    pend_d  = 1'b0;
                end else if (wake_i) begin
                    pend_d  = 1'b1;
                end else begin
                    pend_d  = pend_q;
                end
            end
            ON: begin
                if (cnt_q != {CW{1'b0}}) begin
                    cnt_d   = cnt_dec;
                end else if (pwr_ok_i) begin
                    state_d = DEISO;
                    cnt_d   = ISO_LD;
                end else begin
                    cnt_d   = {CW{1'b0}};
                end
            end
            DEISO: begin
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = WKUP;
                end else begin
                    cnt_d   = cnt_dec;
                end
            end
            WKUP: begin
                if (!req_i) begin
                    state_d = RUN;
                end else begin
                    state_d = WKUP;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = {CW{1'b0}};
                pend_d  = 1'b0;
            end
        endcase

        // Setting on OFF entry takes priority over a coincident clear.
        if ((state_d == OFF) && (state_q != OFF)) begin
            sbf_d = 1'b1;
        end else if (sbf_clr_i) begin
            sbf_d = 1'b0;
        end else begin
            sbf_d = sbf_q;
        end

        iso_d  = is_iso_state(state_d);
        off_d  = (state_d == OFF);
        wkup_d = (state_d == WKUP);
    end

    // State, counter, flags and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            cnt_q   <= {CW{1'b0}};
            pend_q  <= 1'b0;
            sbf_q   <= 1'b0;
            wkup_q  <= 1'b0;
            iso_q   <= 1'b0;
            off_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            sbf_q   <= sbf_d;
            wkup_q  <= wkup_d;
            iso_q   <= iso_d;
            off_q   <= off_d;
        end
    end

    assign state_o   = state_q;
    assign wkup_o    = wkup_q;
    assign iso_en_o  = iso_q;
    assign pwr_off_o = off_q;
    assign sbf_o     = sbf_q;

endmodule

// File: rtl/pwr_dstop_ctrl.sv
// PWR-side responder for the RCC D1/D2/D3 stop handshake: three domain sequencers plus
// the cross-domain wake and ordering gates (D3 goes down last and comes up first).
module pwr_dstop_ctrl
    import pwr_pkg::*;
#(
    parameter int unsigned ISO_CYC = ISO_CYC_DEF,
    parameter int unsigned PUP_CYC = PUP_CYC_DEF,
    parameter int unsigned CW      = CW_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic rcc_pwr_d1_req,
    input  logic rcc_pwr_d2_req,
    input  logic rcc_pwr_d3_req,
    input  logic d1_wkup_src,
    input  logic d2_wkup_src,
    input  logic d3_wkup_src,
    input  logic d1_pwr_ok,
    input  logic d2_pwr_ok,
    input  logic d3_pwr_ok,
    input  logic sbf_clr,
    output logic pwr_d1_wkup,
    output logic pwr_d2_wkup,
    output logic pwr_d3_wkup,
    output logic d1_iso_en,
    output logic d2_iso_en,
    output logic d3_iso_en,
    output logic d1_pwr_off,
    output logic d2_pwr_off,
    output logic d3_pwr_off,
    output logic d1_sbf,
    output logic d2_sbf,
    output logic d3_sbf
);

    pwr_dom_st_e d1_st_s, d2_st_s, d3_st_s;
    logic        d3_wake_s;
    logic        d3_entry_gate_s;
    logic        d12_exit_gate_s;

    assign d3_wake_s       = d1_wkup_src | d2_wkup_src | d3_wkup_src;
    assign d3_entry_gate_s = (d1_st_s == OFF) && (d2_st_s == OFF);
    assign d12_exit_gate_s = (d3_st_s == RUN);

    pwr_dom_fsm #(.ISO_CYC(ISO_CYC), .PUP_CYC(PUP_CYC), .CW(CW)) u_d1 (
        .clk_i        (sys_clk),
        .rst_i        (sys_rst),
        .req_i        (rcc_pwr_d1_req),
        .wake_i       (d1_wkup_src),
        .entry_gate_i (1'b1),
        .exit_gate_i  (d12_exit_gate_s),
        .pwr_ok_i     (d1_pwr_ok),
        .sbf_clr_i    (sbf_clr),
        .state_o      (d1_st_s),
        .wkup_o       (pwr_d1_wkup),
        .iso_en_o     (d1_iso_en),
        .pwr_off_o    (d1_pwr_off),
        .sbf_o        (d1_sbf)
    );

    pwr_dom_fsm #(.ISO_CYC(ISO_CYC), .PUP_CYC(PUP_CYC), .CW(CW)) u_d2 (
        .clk_i        (sys_clk),
        .rst_i        (sys_rst),
        .req_i        (rcc_pwr_d2_req),
        .wake_i       (d2_wkup_src),
        .entry_gate_i (1'b1),
        .exit_gate_i  (d12_exit_gate_s),
        .pwr_ok_i     (d2_pwr_ok),
        .sbf_clr_i    (sbf_clr),
        .state_o      (d2_st_s),
        .wkup_o       (pwr_d2_wkup),
        .iso_en_o     (d2_iso_en),
        .pwr_off_o    (d2_pwr_off),
        .sbf_o        (d2_sbf)
    );

    pwr_dom_fsm #(.ISO_CYC(ISO_CYC), .PUP_CYC(PUP_CYC), .CW(CW)) u_d3 (
        .clk_i        (sys_clk),
        .rst_i        (sys_rst),
        .req_i        (rcc_pwr_d3_req),
        .wake_i       (d3_wake_s),
        .entry_gate_i (d3_entry_gate_s),
        .exit_gate_i  (1'b1),
        .pwr_ok_i     (d3_pwr_ok),
        .sbf_clr_i    (sbf_clr),
        .state_o      (d3_st_s),
        .wkup_o       (pwr_d3_wkup),
        .iso_en_o     (d3_iso_en),
        .pwr_off_o    (d3_pwr_off),
        .sbf_o        (d3_sbf)
    );

endmodule

// File: tb/tb_pwr_dstop_ctrl.sv
// Directed-vector bench for pwr_dstop_ctrl with the default ISO_CYC=4, PUP_CYC=16.
module tb_pwr_dstop_ctrl;

    logic sys_clk = 1'b0;
    logic sys_rst;
    logic r1, r2, r3;
    logic w1, w2, w3;
    logic ok1, ok2, ok3;
    logic sbf_clr;
    logic pwr_d1_wkup, pwr_d2_wkup, pwr_d3_wkup;
    logic d1_iso_en, d2_iso_en, d3_iso_en;
    logic d1_pwr_off, d2_pwr_off, d3_pwr_off;
    logic d1_sbf, d2_sbf, d3_sbf;
    logic [11:0] all_o;

    int vec = 0;
    int err = 0;
    int cyc = 0;

    assign all_o = {pwr_d1_wkup, pwr_d2_wkup, pwr_d3_wkup, d1_iso_en, d2_iso_en, d3_iso_en,
                    d1_pwr_off, d2_pwr_off, d3_pwr_off, d1_sbf, d2_sbf, d3_sbf};

    always #5 sys_clk = ~sys_clk;

    pwr_dstop_ctrl dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .rcc_pwr_d1_req (r1),
        .rcc_pwr_d2_req (r2),
        .rcc_pwr_d3_req (r3),
        .d1_wkup_src    (w1),
        .d2_wkup_src    (w2),
        .d3_wkup_src    (w3),
        .d1_pwr_ok      (ok1),
        .d2_pwr_ok      (ok2),
        .d3_pwr_ok      (ok3),
        .sbf_clr        (sbf_clr),
        .pwr_d1_wkup    (pwr_d1_wkup),
        .pwr_d2_wkup    (pwr_d2_wkup),
        .pwr_d3_wkup    (pwr_d3_wkup),
        .d1_iso_en      (d1_iso_en),
        .d2_iso_en      (d2_iso_en),
        .d3_iso_en      (d3_iso_en),
        .d1_pwr_off     (d1_pwr_off),
        .d2_pwr_off     (d2_pwr_off),
        .d3_pwr_off     (d3_pwr_off),
        .d1_sbf         (d1_sbf),
        .d2_sbf         (d2_sbf),
        .d3_sbf         (d3_sbf)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        {r1, r2, r3, w1, w2, w3, sbf_clr} = 7'b0;
        {ok1, ok2, ok3} = 3'b111;
        #1;
        vec++; if (all_o !== 12'h000) begin err++; $display("FAIL reset_outs: got %h exp %h", all_o, 12'h000); end
        tick();
        tick();
        sys_rst = 1'b0;
        tick();
        vec++; if (all_o !== 12'h000) begin err++; $display("FAIL post_reset_outs: got %h exp %h", all_o, 12'h000); end
    endtask

    task automatic test_d1_only();
        cyc = 0;
        r1 = 1'b1;
        tick();
        vec++; if (d1_iso_en !== 1'b1) begin err++; $display("FAIL d1_iso_c1: got %b exp 1", d1_iso_en); end
        vec++; if (d1_pwr_off !== 1'b0) begin err++; $display("FAIL d1_off_c1: got %b exp 0", d1_pwr_off); end
        run_to(4);
        vec++; if (d1_pwr_off !== 1'b0) begin err++; $display("FAIL d1_off_c4: got %b exp 0", d1_pwr_off); end
        tick();
        vec++; if (d1_pwr_off !== 1'b1) begin err++; $display("FAIL d1_off_c5: got %b exp 1", d1_pwr_off); end
        vec++; if (d1_sbf !== 1'b1) begin err++; $display("FAIL d1_sbf_c5: got %b exp 1", d1_sbf); end
        run_to(20);
        w1 = 1'b1;
        tick();
        w1 = 1'b0;
        vec++; if ({d1_iso_en, d1_pwr_off} !== 2'b10) begin err++; $display("FAIL d1_on_c21: got %b exp 10", {d1_iso_en, d1_pwr_off}); end
        run_to(36);
        vec++; if (d1_iso_en !== 1'b1) begin err++; $display("FAIL d1_iso_c36: got %b exp 1", d1_iso_en); end
        tick();
        vec++; if ({d1_iso_en, pwr_d1_wkup} !== 2'b00) begin err++; $display("FAIL d1_deiso_c37: got %b exp 00", {d1_iso_en, pwr_d1_wkup}); end
        run_to(40);
        vec++; if (pwr_d1_wkup !== 1'b0) begin err++; $display("FAIL d1_wkup_c40: got %b exp 0", pwr_d1_wkup); end
        tick();
        vec++; if (pwr_d1_wkup !== 1'b1) begin err++; $display("FAIL d1_wkup_c41: got %b exp 1", pwr_d1_wkup); end
        run_to(43);
        vec++; if (pwr_d1_wkup !== 1'b1) begin err++; $display("FAIL d1_wkup_hold: got %b exp 1", pwr_d1_wkup); end
        r1 = 1'b0;
        tick();
        vec++; if ({pwr_d1_wkup, d1_iso_en, d1_sbf} !== 3'b001) begin err++; $display("FAIL d1_release: got %b exp 001", {pwr_d1_wkup, d1_iso_en, d1_sbf}); end
        sbf_clr = 1'b1;
        tick();
        sbf_clr = 1'b0;
        vec++; if (d1_sbf !== 1'b0) begin err++; $display("FAIL d1_sbf_clr: got %b exp 0", d1_sbf); end
    endtask

    task automatic test_abort();
        logic exp_iso, exp_wk;
        cyc = 0;
        r2 = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            if (i == 3) begin
                w2 = 1'b1;
            end
            tick();
            w2 = 1'b0;
            if (i == 3) begin
                r2 = 1'b0;
            end
            exp_iso = (cyc >= 1) && (cyc <= 2);
            exp_wk  = (cyc == 7);
            vec++;
            if ({d2_iso_en, d2_pwr_off, d2_sbf, pwr_d2_wkup} !== {exp_iso, 1'b0, 1'b0, exp_wk}) begin
                err++;
                $display("FAIL abort_c%0d: got iso/off/sbf/wk %b exp %b", cyc,
                         {d2_iso_en, d2_pwr_off, d2_sbf, pwr_d2_wkup}, {exp_iso, 1'b0, 1'b0, exp_wk});
            end
        end
    endtask

    task automatic test_d3_gating();
        cyc = 0;
        r3 = 1'b1;
        run_to(3);
        vec++; if (d3_iso_en !== 1'b0) begin err++; $display("FAIL d3_gated: got %b exp 0", d3_iso_en); end
        r1 = 1'b1;
        r2 = 1'b1;
        run_to(8);
        vec++; if ({d1_pwr_off, d2_pwr_off, d3_iso_en} !== 3'b110) begin err++; $display("FAIL d3_wait_c8: got %b exp 110", {d1_pwr_off, d2_pwr_off, d3_iso_en}); end
        tick();
        vec++; if (d3_iso_en !== 1'b1) begin err++; $display("FAIL d3_iso_c9: got %b exp 1", d3_iso_en); end
        run_to(12);
        vec++; if (d3_pwr_off !== 1'b0) begin err++; $display("FAIL d3_off_c12: got %b exp 0", d3_pwr_off); end
        tick();
        vec++; if ({d3_pwr_off, d3_sbf} !== 2'b11) begin err++; $display("FAIL d3_off_c13: got %b exp 11", {d3_pwr_off, d3_sbf}); end
    endtask

    task automatic test_ordered_wake();
        cyc = 0;
        w1 = 1'b1;
        tick();
        w1 = 1'b0;
        vec++; if ({d3_pwr_off, d3_iso_en, d1_pwr_off} !== 3'b011) begin err++; $display("FAIL ow_c1: got %b exp 011", {d3_pwr_off, d3_iso_en, d1_pwr_off}); end
        run_to(20);
        vec++; if ({pwr_d3_wkup, d3_iso_en} !== 2'b00) begin err++; $display("FAIL ow_d3_c20: got %b exp 00", {pwr_d3_wkup, d3_iso_en}); end
        tick();
        vec++; if ({pwr_d3_wkup, d1_pwr_off} !== 2'b11) begin err++; $display("FAIL ow_d3_wkup_c21: got %b exp 11", {pwr_d3_wkup, d1_pwr_off}); end
        r3 = 1'b0;
        ok1 = 1'b0;
        tick();
        vec++; if ({pwr_d3_wkup, d1_pwr_off} !== 2'b01) begin err++; $display("FAIL ow_d3_run_c22: got %b exp 01", {pwr_d3_wkup, d1_pwr_off}); end
        tick();
        vec++; if ({d1_pwr_off, d1_iso_en, d2_pwr_off} !== 3'b011) begin err++; $display("FAIL ow_d1_on_c23: got %b exp 011", {d1_pwr_off, d1_iso_en, d2_pwr_off}); end
    endtask

    task automatic test_pwr_ok_late();
        run_to(50);
        vec++; if ({d1_iso_en, d1_pwr_off, pwr_d1_wkup} !== 3'b100) begin err++; $display("FAIL pok_wait_c50: got %b exp 100", {d1_iso_en, d1_pwr_off, pwr_d1_wkup}); end
        run_to(63);
        vec++; if (d1_iso_en !== 1'b1) begin err++; $display("FAIL pok_wait_c63: got %b exp 1", d1_iso_en); end
        ok1 = 1'b1;
        tick();
        vec++; if (d1_iso_en !== 1'b0) begin err++; $display("FAIL pok_deiso_c64: got %b exp 0", d1_iso_en); end
        r1 = 1'b0;
        run_to(67);
        vec++; if (pwr_d1_wkup !== 1'b0) begin err++; $display("FAIL pok_wkup_c67: got %b exp 0", pwr_d1_wkup); end
        tick();
        vec++; if (pwr_d1_wkup !== 1'b1) begin err++; $display("FAIL pok_wkup_c68: got %b exp 1", pwr_d1_wkup); end
        tick();
        vec++; if (pwr_d1_wkup !== 1'b0) begin err++; $display("FAIL pok_wkup_c69: got %b exp 0", pwr_d1_wkup); end
    endtask

    task automatic test_reset_mid();
        cyc = 0;
        r1 = 1'b1;
        r3 = 1'b1;
        run_to(10);
        vec++; if ({d3_pwr_off, d3_sbf, d2_pwr_off} !== 3'b111) begin err++; $display("FAIL rm_pre: got %b exp 111", {d3_pwr_off, d3_sbf, d2_pwr_off}); end
        #2;
        sys_rst = 1'b1;
        #1;
        vec++; if (all_o !== 12'h000) begin err++; $display("FAIL rm_async: got %h exp %h", all_o, 12'h000); end
        {r1, r2, r3} = 3'b000;
        tick();
        sys_rst = 1'b0;
        tick();
        vec++; if (all_o !== 12'h000) begin err++; $display("FAIL rm_after: got %h exp %h", all_o, 12'h000); end
        r2 = 1'b1;
        tick();
        r2 = 1'b0;
        vec++; if ({d2_iso_en, d3_iso_en} !== 2'b10) begin err++; $display("FAIL rm_run: got %b exp 10", {d2_iso_en, d3_iso_en}); end
    endtask

    task automatic test_sbf_race();
        cyc = 0;
        r1 = 1'b1;
        run_to(4);
        vec++; if (d1_sbf !== 1'b0) begin err++; $display("FAIL race_pre: got %b exp 0", d1_sbf); end
        sbf_clr = 1'b1;
        tick();
        sbf_clr = 1'b0;
        vec++; if ({d1_pwr_off, d1_sbf} !== 2'b11) begin err++; $display("FAIL race_set_wins: got %b exp 11", {d1_pwr_off, d1_sbf}); end
        sbf_clr = 1'b1;
        tick();
        sbf_clr = 1'b0;
        vec++; if ({d1_pwr_off, d1_sbf} !== 2'b10) begin err++; $display("FAIL race_clr: got %b exp 10", {d1_pwr_off, d1_sbf}); end
    endtask

    initial begin
        test_reset();
        test_d1_only();
        test_abort();
        test_d3_gating();
        test_ordered_wake();
        test_pwr_ok_late();
        test_reset_mid();
        test_sbf_race();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
